i2c_cfg_seq: RTL

Codec configuration sequencer that sits directly upstream of the I2C byte-write state machine. After reset and a power-up wait it walks a fixed table of register/data pairs and hands each one to the I2C master over a valid/ready command interface. It waits for completion and ACK status, spaces the writes, and raises cfg_done once the ADC enable write succeeds. The table covers slave mode, ADC clock divide, ADC select, IADC select and ADC enable.

---
 rtl/i2c_cfg_if.sv | 23 ++
 rtl/i2c_cfg_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_if.sv
// Command/response channel between the codec configuration sequencer and the I2C byte-write master.
// Handshake: a command transfers on any clock edge where cmd_valid && cmd_ready; while cmd_valid is
// high and cmd_ready low, cmd_dev_addr/cmd_reg_addr/cmd_data hold steady. wr_done is a one-cycle
// completion pulse and wr_ack_ok is meaningful only in that cycle.
interface i2c_cfg_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_data;
    logic       wr_done;
    logic       wr_ack_ok;

    modport master (
        output cmd_valid, cmd_dev_addr, cmd_reg_addr, cmd_data,
        input  cmd_ready, wr_done, wr_ack_ok
    );

    modport slave (
        input  cmd_valid, cmd_dev_addr, cmd_reg_addr, cmd_data,
        output cmd_ready, wr_done, wr_ack_ok
    );
endinterface

// File: rtl/i2c_cfg_seq.sv
// Codec configuration sequencer: power-up wait, then writes a fixed 6-entry register table via the I2C master.
// Optional macro CFG_RETRY_EN re-issues a failed entry up to MAX_RETRY more times before aborting.
module i2c_cfg_seq #(
    parameter logic [6:0]  DEV_ADDR       = 7'h40,
    parameter int unsigned POWERUP_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 4095,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_i,
    i2c_cfg_if.master                          cmd_if,
    output logic                               busy_o,
    output logic                               cfg_done_o,
    output logic                               cfg_err_o,
    output logic [2:0]                         err_index_o,
    output logic [2:0]                         state_o,
    output logic [$clog2(MAX_RETRY+2)-1:0]     retry_cnt_o
);

    localparam int unsigned MAX_AB  = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CNT);
    localparam int unsigned RW      = $clog2(MAX_RETRY + 2);
    localparam logic [2:0]  LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        ST_POWERUP   = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_GAP       = 3'd3,
        ST_FAIL      = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic            valid_q;
    logic [7:0]      reg_q;
    logic [7:0]      data_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [2:0]      err_idx_q;
    logic            retry_pend;

    function automatic logic [15:0] tbl(input logic [2:0] i);
        case (i)
            3'd0:    tbl = 16'h0001;
            3'd1:    tbl = 16'h0100;
            3'd2:    tbl = 16'h0201;
            3'd3:    tbl = 16'h0303;
            3'd4:    tbl = 16'h0401;
            3'd5:    tbl = 16'h0580;
            default: tbl = 16'h0000;
        endcase
    endfunction

`ifdef CFG_RETRY_EN
    logic [RW-1:0] retry_q;
    logic          retry_pend_q;
    assign retry_pend  = retry_pend_q;
    assign retry_cnt_o = retry_q;
`else
    assign retry_pend  = 1'b0;
    assign retry_cnt_o = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_POWERUP;
            cnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            reg_q     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
`ifdef CFG_RETRY_EN
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_POWERUP: begin
                    if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
                        cnt_q            <= '0;
                        {reg_q, data_q}  <= tbl(idx_q);
                        valid_q          <= 1'b1;
                        state_q          <= ST_ISSUE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_if.cmd_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_RESP;
                    end
                end
                // A completion landing on the timeout cycle is honoured rather than treated as a timeout.
                ST_WAIT_RESP: begin
                    if (cmd_if.wr_done) begin
                        cnt_q   <= '0;
                        state_q <= cmd_if.wr_ack_ok ? ST_GAP : ST_FAIL;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_FAIL;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != CW'(GAP_CYCLES - 1)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (retry_pend) begin
                            valid_q <= 1'b1;
                            state_q <= ST_ISSUE;
                        end else if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q           <= idx_q + 3'd1;
                            {reg_q, data_q} <= tbl(idx_q + 3'd1);
                            valid_q         <= 1'b1;
                            state_q         <= ST_ISSUE;
                        end
`ifdef CFG_RETRY_EN
                        retry_pend_q <= 1'b0;
                        if (!retry_pend) retry_q <= '0;
`endif
                    end
                end
                ST_FAIL: begin
`ifdef CFG_RETRY_EN
                    retry_q <= retry_q + 1'b1;
                    if ({1'b0, retry_q} + 1 > (RW + 1)'(MAX_RETRY)) begin
                        err_q     <= 1'b1;
                        err_idx_q <= idx_q;
                        busy_q    <= 1'b0;
                        state_q   <= ST_ERROR;
                    end else begin
                        retry_pend_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= ST_GAP;
                    end
`else
                    err_q     <= 1'b1;
                    err_idx_q <= idx_q;
                    busy_q    <= 1'b0;
                    state_q   <= ST_ERROR;
`endif
                end
                ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        err_idx_q <= '0;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_POWERUP;
`ifdef CFG_RETRY_EN
                        retry_q      <= '0;
                        retry_pend_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= ST_POWERUP;
            endcase
        end
    end

    assign cmd_if.cmd_valid    = valid_q;
    assign cmd_if.cmd_dev_addr = DEV_ADDR;
    assign cmd_if.cmd_reg_addr = reg_q;
    assign cmd_if.cmd_data     = data_q;
    assign busy_o              = busy_q;
    assign cfg_done_o          = done_q;
    assign cfg_err_o           = err_q;
    assign err_index_o         = err_idx_q;
    assign state_o             = state_q;

endmodule
